axi_read_responder: RTL and testbench

AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

---
 rtl/axi_read_responder.sv | 165 ++++++++++++++++
 tb/tb_axi_read_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_responder.sv
// axi_read_responder
//   AXI4 read-channel slave in front of a synchronous SRAM. Accepts one burst
//   at a time on AR. Each beat is fetched from the SRAM and returned on R.
//   Beats that fall outside [MEM_BASE, MEM_BASE+MEM_SIZE-8] are answered with
//   DECERR and zero data, and the SRAM is not touched for them.
//
// Ports
//   ACLK, ARESETn       clock, synchronous active-low reset
//   ARVALID/ARREADY     read address handshake
//   ARADDR, ARLEN       burst start byte address, beats minus one
//   ARPROT              accepted and ignored
//   RVALID/RREADY       read data handshake
//   RDATA, RLAST, RRESP read data, final-beat flag, OKAY/DECERR response
//   mem_en, mem_addr    SRAM read strobe and 8-byte aligned byte address
//   mem_rdata           SRAM read data, valid the cycle after mem_en
module axi_read_responder #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 64,
  parameter logic [ADDR_W-1:0] MEM_BASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] MEM_SIZE = 32'h0800_0000
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [2:0]        ARPROT,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic              RLAST,
  output logic [1:0]        RRESP,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Last decoded beat address, computed one bit wider so a region ending at
  // the top of the address space cannot wrap.
  localparam logic [ADDR_W:0] LAST_ADDR =
    {1'b0, MEM_BASE} + {1'b0, MEM_SIZE} - (ADDR_W+1)'(8);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP
  } state_e;

  state_e              state_q,   state_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [7:0]          len_q,     len_d;
  logic [7:0]          cnt_q,     cnt_d;
  logic                arready_q, arready_d;
  logic                rvalid_q,  rvalid_d;
  logic [1:0]          rresp_q,   rresp_d;
  logic                first_q,   first_d;
  logic [DATA_W-1:0]   rdata_q,   rdata_d;

  logic [DATA_W-1:0]   rdata_live;
  logic                beat_last;

  // ARPROT and the low address bits carry no meaning for this slave.
  logic unused_inputs;
  assign unused_inputs = ^{ARPROT, ARADDR[2:0]};

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= {1'b0, MEM_BASE}) && ({1'b0, a} <= LAST_ADDR);
  endfunction

  assign beat_last  = (cnt_q == len_q);
  assign rdata_live = (rresp_q == RESP_OKAY) ? mem_rdata : '0;

  // SRAM data only arrives in the first RESP cycle, so that cycle forwards it
  // straight through while rdata_q captures it; later stall cycles replay the
  // captured copy, keeping RDATA stable until the handshake.
  assign RDATA    = first_q ? rdata_live : rdata_q;
  assign RVALID   = rvalid_q;
  assign RRESP    = rresp_q;
  assign RLAST    = rvalid_q && beat_last;
  assign ARREADY  = arready_q;
  assign mem_en   = (state_q == FETCH) && in_range(addr_q);
  assign mem_addr = addr_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    first_d   = 1'b0;
    rdata_d   = rdata_q;

    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (ARVALID && arready_q) begin
          addr_d    = {ARADDR[ADDR_W-1:3], 3'b000};
          len_d     = ARLEN;
          cnt_d     = '0;
          arready_d = 1'b0;
          state_d   = FETCH;
        end
      end

      FETCH: begin
        rvalid_d = 1'b1;
        rresp_d  = in_range(addr_q) ? RESP_OKAY : RESP_DECERR;
        first_d  = 1'b1;
        state_d  = RESP;
      end

      RESP: begin
        if (first_q) begin
          rdata_d = rdata_live;
        end
        if (rvalid_q && RREADY) begin
          rvalid_d = 1'b0;
          if (beat_last) begin
            arready_d = 1'b1;
            state_d   = IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(8);
            cnt_d   = cnt_q + 8'd1;
            state_d = FETCH;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      first_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      first_q   <= first_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_read_responder.sv
// tb_axi_read_responder
//   Scoreboard bench for axi_read_responder. Each accepted read request pushes
//   its expected SRAM addresses and R beats; a negedge monitor pops and
//   compares them as the DUT produces them, and also checks beat latency,
//   stability under backpressure and ARREADY behaviour.
module tb_axi_read_responder;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 64;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SIZE = 32'h0800_0000;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          ARVALID;
  logic          ARREADY;
  logic [AW-1:0] ARADDR;
  logic [7:0]    ARLEN;
  logic [2:0]    ARPROT;
  logic          RVALID;
  logic          RREADY;
  logic [DW-1:0] RDATA;
  logic          RLAST;
  logic [1:0]    RRESP;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;

  axi_read_responder #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .MEM_BASE(BASE),
    .MEM_SIZE(SIZE)
  ) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .ARADDR   (ARADDR),
    .ARLEN    (ARLEN),
    .ARPROT   (ARPROT),
    .RVALID   (RVALID),
    .RREADY   (RREADY),
    .RDATA    (RDATA),
    .RLAST    (RLAST),
    .RRESP    (RRESP),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] mem_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ev_cyc  = 0;
  int beats_seen = 0;

  function automatic logic [63:0] mem_f(input logic [31:0] a);
    if (a == 32'h8000_0010) return 64'hDEAD_BEEF_0000_0001;
    return {a ^ 32'h5A5A_0F0F, a};
  endfunction

  // Synchronous SRAM: data appears the cycle after the strobe and holds.
  always @(posedge ACLK) begin
    cyc <= cyc + 1;
    if (mem_en) mem_rdata <= mem_f(mem_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_burst(input logic [31:0] a, input logic [7:0] len);
    logic [31:0] ba;
    logic        inr;
    beat_t       b;
    ba = a & 32'hFFFF_FFF8;
    for (int i = 0; i <= int'(len); i++) begin
      inr = (ba >= BASE) && (ba <= BASE + SIZE - 32'd8);
      if (inr) mem_q.push_back(ba);
      b.data = inr ? mem_f(ba) : 64'd0;
      b.resp = inr ? 2'b00 : 2'b11;
      b.last = (i == int'(len));
      exp_q.push_back(b);
      ba = ba + 32'd8;
    end
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] len, input bit keep);
    bit hs;
    int n;
    hs = 1'b0;
    n  = 0;
    ARVALID = 1'b1;
    ARADDR  = a;
    ARLEN   = len;
    ARPROT  = 3'($urandom);
    while (!hs && n < 600) begin
      @(negedge ACLK);
      if (ARREADY) hs = 1'b1;
      else n++;
    end
    if (!hs) begin
      check("ar_timeout", 64'd0, 64'd1);
    end else begin
      check("ar_overlap", 64'(exp_q.size()), 64'd0);
      push_burst(a, len);
    end
    @(posedge ACLK);
    #1;
    if (!keep) ARVALID = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    int n;
    done = 1'b0;
    n    = 0;
    while (!done && n < 2000) begin
      @(negedge ACLK);
      if (exp_q.size() == 0 && mem_q.size() == 0 && !RVALID && ARREADY) done = 1'b1;
      else n++;
    end
    if (!done) check("idle_timeout", 64'd0, 64'd1);
    @(posedge ACLK);
    #1;
  endtask

  // Monitor: sample away from the active edge.
  initial begin : monitor
    logic        rv_prev, hs_prev, rst_prev, lasths_prev, rlast_prev, hs;
    logic [63:0] rdata_prev;
    logic [1:0]  rresp_prev;
    logic [31:0] ea;
    beat_t       eb;
    rv_prev = 0; hs_prev = 0; rst_prev = 0; lasths_prev = 0; rlast_prev = 0;
    rdata_prev = '0; rresp_prev = '0;
    forever begin
      @(negedge ACLK);
      if (mem_en) begin
        check("mem_lat", 64'(cyc - ev_cyc), 64'd1);
        check("mem_en_with_rvalid", 64'(RVALID), 64'd0);
        if (mem_q.size() == 0) begin
          check("mem_en_extra", 64'd1, 64'd0);
        end else begin
          ea = mem_q.pop_front();
          check("mem_addr", 64'(mem_addr), 64'(ea));
        end
      end
      if (RVALID && !rv_prev && ARESETn) check("rvalid_lat", 64'(cyc - ev_cyc), 64'd2);
      if (rv_prev && !hs_prev && rst_prev) begin
        check("hold_rvalid", 64'(RVALID), 64'd1);
        check("hold_rdata", RDATA, rdata_prev);
        check("hold_rlast", 64'(RLAST), 64'(rlast_prev));
        check("hold_rresp", 64'(RRESP), 64'(rresp_prev));
      end
      if (lasths_prev && rst_prev) check("arready_back", 64'(ARREADY), 64'd1);
      if (RVALID || mem_en) check("arready_busy", 64'(ARREADY), 64'd0);
      hs = RVALID && RREADY && ARESETn;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("r_beat_extra", 64'd1, 64'd0);
        end else begin
          eb = exp_q.pop_front();
          check("rdata", RDATA, eb.data);
          check("rresp", 64'(RRESP), 64'(eb.resp));
          check("rlast", 64'(RLAST), 64'(eb.last));
        end
        beats_seen++;
        if (!RLAST) ev_cyc = cyc;
      end
      if (ARVALID && ARREADY && ARESETn) ev_cyc = cyc;
      rv_prev     = RVALID;
      hs_prev     = hs;
      rdata_prev  = RDATA;
      rlast_prev  = RLAST;
      rresp_prev  = RRESP;
      rst_prev    = ARESETn;
      lasths_prev = hs && RLAST;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin : stim
    int b0;
    int n;
    ARESETn = 1'b0;
    ARVALID = 1'b0;
    ARADDR  = '0;
    ARLEN   = '0;
    ARPROT  = '0;
    RREADY  = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_arready", 64'(ARREADY), 64'd0);
    check("rst_rvalid", 64'(RVALID), 64'd0);
    check("rst_rlast", 64'(RLAST), 64'd0);
    check("rst_rresp", 64'(RRESP), 64'd0);
    check("rst_rdata", RDATA, 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    check("arready_after_rst", 64'(ARREADY), 64'd1);

    // Single beat, burst of 4.
    send_ar(32'h8000_0010, 8'd0, 1'b0);
    wait_idle();
    send_ar(32'h8000_0000, 8'd3, 1'b0);
    wait_idle();

    // Backpressure: stall beat 1 for 5 cycles.
    RREADY = 1'b0;
    send_ar(32'h8000_0040, 8'd1, 1'b0);
    n = 0;
    while (!RVALID && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    check("bp_rvalid_seen", 64'(RVALID), 64'd1);
    repeat (5) @(posedge ACLK);
    #1;
    RREADY = 1'b1;
    wait_idle();

    // Decode error and region-end crossing.
    send_ar(32'h0000_1000, 8'd0, 1'b0);
    wait_idle();
    send_ar(BASE + SIZE - 32'd8, 8'd1, 1'b0);
    wait_idle();

    // Misaligned start address.
    send_ar(32'h8000_0013, 8'd0, 1'b0);
    wait_idle();

    // ARVALID held across two requests.
    send_ar(32'h8000_0100, 8'd2, 1'b1);
    send_ar(32'h8000_0200, 8'd1, 1'b0);
    wait_idle();

    // A few random bursts straddling the region end.
    for (int i = 0; i < 4; i++) begin
      send_ar(BASE + SIZE - 32'($urandom_range(0, 40)), 8'($urandom_range(0, 5)), 1'b0);
      wait_idle();
    end

    // Reset during beat 3 of an 8-beat burst.
    b0 = beats_seen;
    send_ar(32'h8000_0800, 8'd7, 1'b0);
    n = 0;
    while (beats_seen < b0 + 2 && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    check("rst_mid_beats", 64'(beats_seen - b0), 64'd2);
    @(posedge ACLK);
    #1;
    RREADY = 1'b0;
    @(posedge ACLK);
    #1;
    check("rst_mid_pre_rvalid", 64'(RVALID), 64'd1);
    ARESETn = 1'b0;
    @(posedge ACLK);
    #1;
    exp_q.delete();
    mem_q.delete();
    check("rst_mid_rvalid", 64'(RVALID), 64'd0);
    check("rst_mid_arready", 64'(ARREADY), 64'd0);
    ARESETn = 1'b1;
    RREADY  = 1'b1;
    @(posedge ACLK);
    #1;
    check("rst_mid_arready_rel", 64'(ARREADY), 64'd1);
    b0 = beats_seen;
    repeat (20) @(posedge ACLK);
    #1;
    check("rst_mid_no_stray", 64'(beats_seen - b0), 64'd0);

    // Normal operation resumes.
    send_ar(32'h8000_0020, 8'd2, 1'b0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
